yutorina_bus_slave_dec: RTL and testbench
=========================================

Name: yutorina_bus_slave_dec

Overview:
Parametrised, registered successor to the bus address decoder. It decodes the master word address into one of NUM_SLAVES active-low chip selects and holds the select for the whole transaction. It also tracks the slave ready handshake, answers unmapped or disabled slaves with a bus error, and aborts stalled accesses after a timeout. It sits between the bus arbiter output and the slave ready/read-data mux.

Parameters:
NUM_SLAVES, 8, number of slave ports (1..2**INDEX_W)
ADDR_W, 30, word address width
INDEX_W, 3, slave index field width, taken from the MSBs m_addr[ADDR_W-1 -: INDEX_W]
TIMEOUT, 255, max ACCESS cycles without slave ready before abort (>=1)
TO_W, 8, timeout counter width (2**TO_W > TIMEOUT)
ERRCNT_W, 8, error counter width

Ports:
clk  input  1  single clock; all state updates on rising edge
reset_  input  1  asynchronous, active-low reset
m_as_  input  1  master address strobe, active-low, sampled in IDLE only
m_addr  input  ADDR_W  master word address
slave_en  input  NUM_SLAVES  per-slave map enable; 0 = unmapped
s_rdy_  input  NUM_SLAVES  slave ready, active-low
s_cs_  output  NUM_SLAVES  registered chip selects, active-low, one-hot-low or all high
m_rdy_  output  1  ready to master, active-low
m_err  output  1  bus error flag, valid while m_rdy_ low
busy  output  1  high in ACCESS or ERR
sel_index  output  INDEX_W  registered index of the current/last selected slave (for read-data mux)
err_cnt  output  ERRCNT_W  saturating count of errors since reset

Behaviour:
- Reset, asynchronous while reset_=0:
  - state=IDLE
  - s_cs_ all 1, m_rdy_=1, m_err=0, busy=0, sel_index=0, err_cnt=0, timer=0
  - Reset asserted mid-access drops s_cs_ immediately; no error is counted.
- idx = m_addr[ADDR_W-1 -: INDEX_W]. valid = (idx < NUM_SLAVES) && slave_en[idx].
- IDLE:
  - m_as_=0 and valid: next cycle state=ACCESS, s_cs_[idx]=0, sel_index=idx, timer=0. Latency from strobe to chip select is 1 cycle.
  - m_as_=0 and !valid: next state=ERR; s_cs_ stays all 1.
  - m_as_=1: stay in IDLE.
- ACCESS:
  - m_as_ and m_addr are ignored; the select is held constant.
  - m_rdy_ = s_rdy_[sel_index], combinational pass-through, with m_err=0.
  - s_rdy_[sel_index]=0: next state=IDLE and s_cs_ all 1.
  - Otherwise timer increments.
  - timer==TIMEOUT-1 with ready still high: next state=ERR and s_cs_ all 1 (abort).
  - Ready and timeout in the same cycle: ready wins; no error.
  - Ready from non-selected slaves is ignored.
- ERR:
  - Lasts exactly 1 cycle, with m_rdy_=0 and m_err=1.
  - err_cnt increments, saturating at all ones.
  - Next state=IDLE.
- Back-to-back accesses: a new m_as_ is accepted in the first IDLE cycle after completion, so minimum transaction spacing is 2 cycles.
- busy = (state != IDLE).
- m_rdy_ in IDLE is 1.

Test Plan:
- Reset, then strobe m_addr with idx=5 and slave_en=8'hFF -> next cycle s_cs_=8'b1101_1111, sel_index=5. Drive s_rdy_[5]=0 on cycle 3 -> m_rdy_=0, m_err=0 that cycle; s_cs_=8'hFF next cycle.
- slave_en=8'hFB, strobe idx=2 -> s_cs_ stays 8'hFF; 1 cycle later m_rdy_=0, m_err=1 for exactly 1 cycle; err_cnt=1.
- NUM_SLAVES=6 build, strobe idx=7 -> error response as above, no chip select.
- TIMEOUT=4, idx=0, no ready -> s_cs_[0] low for 4 cycles, then ERR pulse, err_cnt increments. Repeat with s_rdy_[0]=0 on the 4th cycle -> normal completion, no error.
- During ACCESS to slave 1:
  - change m_addr and pulse m_as_ -> s_cs_ unchanged.
  - pulse s_rdy_[3]=0 -> ignored.
  - assert reset_=0 -> s_cs_ all 1 and busy=0 asynchronously; err_cnt=0.
- ERRCNT_W=2, force 5 errors -> err_cnt saturates at 3.

Source files
------------

// File: rtl/yutorina_bus_slave_dec.sv
// Registered bus slave decoder: one-hot-low chip select held for the whole access,
// with slave-ready pass-through, bus-error reply for unmapped slaves, and a stall timeout.
module yutorina_bus_slave_dec #(
  parameter int NUM_SLAVES = 8,
  parameter int ADDR_W     = 30,
  parameter int INDEX_W    = 3,
  parameter int TIMEOUT    = 255,
  parameter int TO_W       = 8,
  parameter int ERRCNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  reset_,
  input  logic                  m_as_,
  input  logic [ADDR_W-1:0]     m_addr,
  input  logic [NUM_SLAVES-1:0] slave_en,
  input  logic [NUM_SLAVES-1:0] s_rdy_,
  output logic [NUM_SLAVES-1:0] s_cs_,
  output logic                  m_rdy_,
  output logic                  m_err,
  output logic                  busy,
  output logic [INDEX_W-1:0]    sel_index,
  output logic [ERRCNT_W-1:0]   err_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ERR    = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [NUM_SLAVES-1:0] s_cs_q, s_cs_d;
  logic [INDEX_W-1:0]    sel_index_q, sel_index_d;
  logic [TO_W-1:0]       timer_q, timer_d;
  logic [ERRCNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic [INDEX_W-1:0]    idx;
  logic                  idx_valid;
  logic [NUM_SLAVES-1:0] cs_dec;
  logic                  sel_rdy_;
  logic                  m_rdy_o;
  logic                  m_err_o;
  logic                  addr_lo_unused;

  assign idx            = m_addr[ADDR_W-1 -: INDEX_W];
  assign addr_lo_unused = ^m_addr[ADDR_W-INDEX_W-1:0];

  // Loop-based decode keeps indices beyond NUM_SLAVES from ever reaching slave_en.
  always_comb begin
    idx_valid = 1'b0;
    cs_dec    = '1;
    sel_rdy_  = 1'b1;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx == INDEX_W'(i)) begin
        idx_valid = slave_en[i];
        cs_dec[i] = 1'b0;
      end
      if (sel_index_q == INDEX_W'(i)) begin
        sel_rdy_ = s_rdy_[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    s_cs_d      = s_cs_q;
    sel_index_d = sel_index_q;
    timer_d     = timer_q;
    err_cnt_d   = err_cnt_q;
    m_rdy_o     = 1'b1;
    m_err_o     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!m_as_) begin
          if (idx_valid) begin
            state_d     = ST_ACCESS;
            s_cs_d      = cs_dec;
            sel_index_d = idx;
            timer_d     = '0;
          end else begin
            state_d = ST_ERR;
          end
        end
      end
      ST_ACCESS: begin
        m_rdy_o = sel_rdy_;
        if (!sel_rdy_) begin
          state_d = ST_IDLE;
          s_cs_d  = '1;
        end else if (timer_q == TO_W'(TIMEOUT - 1)) begin
          state_d = ST_ERR;
          s_cs_d  = '1;
        end else begin
          timer_d = timer_q + TO_W'(1);
        end
      end
      ST_ERR: begin
        m_rdy_o = 1'b0;
        m_err_o = 1'b1;
        state_d = ST_IDLE;
        if (err_cnt_q != '1) begin
          err_cnt_d = err_cnt_q + ERRCNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        s_cs_d  = '1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q     <= ST_IDLE;
      s_cs_q      <= '1;
      sel_index_q <= '0;
      timer_q     <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      s_cs_q      <= s_cs_d;
      sel_index_q <= sel_index_d;
      timer_q     <= timer_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign s_cs_     = s_cs_q;
  assign m_rdy_    = m_rdy_o;
  assign m_err     = m_err_o;
  assign busy      = (state_q != ST_IDLE);
  assign sel_index = sel_index_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_yutorina_bus_slave_dec.sv
// Bench for yutorina_bus_slave_dec: 6-slave build, short timeout, 2-bit error counter;
// transaction-level model checked every cycle plus directed literal expectations.
module tb_yutorina_bus_slave_dec;

  localparam int NS = 6;
  localparam int AW = 30;
  localparam int IW = 3;
  localparam int TO = 4;
  localparam int EW = 2;

  logic          clk = 1'b0;
  logic          reset_;
  logic          m_as_;
  logic [AW-1:0] m_addr;
  logic [NS-1:0] slave_en;
  logic [NS-1:0] s_rdy_;
  logic [NS-1:0] s_cs_;
  logic          m_rdy_;
  logic          m_err;
  logic          busy;
  logic [IW-1:0] sel_index;
  logic [EW-1:0] err_cnt;

  int tests = 0;
  int fails = 0;

  yutorina_bus_slave_dec #(
    .NUM_SLAVES(NS), .ADDR_W(AW), .INDEX_W(IW),
    .TIMEOUT(TO), .TO_W(3), .ERRCNT_W(EW)
  ) dut (
    .clk(clk), .reset_(reset_), .m_as_(m_as_), .m_addr(m_addr),
    .slave_en(slave_en), .s_rdy_(s_rdy_), .s_cs_(s_cs_), .m_rdy_(m_rdy_),
    .m_err(m_err), .busy(busy), .sel_index(sel_index), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: which slave is in an open access and for how long,
  // whether an error reply is due this cycle, and the total error count.
  int  mdl_sel   = -1;
  int  mdl_age   = 0;
  bit  mdl_err   = 1'b0;
  int  mdl_errs  = 0;
  int  mdl_last  = 0;
  bit  mdl_valid = 1'b0;

  always @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      mdl_sel = -1; mdl_age = 0; mdl_err = 1'b0; mdl_errs = 0; mdl_last = 0;
      mdl_valid = 1'b1;
    end else if (mdl_err) begin
      mdl_err  = 1'b0;
      mdl_errs = (mdl_errs + 1 > 3) ? 3 : mdl_errs + 1;
    end else if (mdl_sel >= 0) begin
      if (s_rdy_[mdl_sel] == 1'b0) begin
        mdl_sel = -1;
      end else if (mdl_age + 1 >= TO) begin
        mdl_sel = -1;
        mdl_err = 1'b1;
      end else begin
        mdl_age++;
      end
    end else if (m_as_ == 1'b0) begin
      int idx;
      idx = int'(m_addr >> (AW - IW));
      if (idx < NS && slave_en[idx]) begin
        mdl_sel = idx; mdl_last = idx; mdl_age = 0;
      end else begin
        mdl_err = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (mdl_valid) begin
      logic [NS-1:0] e_cs;
      logic          e_rdy;
      e_cs  = '1;
      e_rdy = 1'b1;
      if (mdl_sel >= 0) begin
        e_cs[mdl_sel] = 1'b0;
        e_rdy = s_rdy_[mdl_sel];
      end
      if (mdl_err) e_rdy = 1'b0;
      chk("mdl_s_cs_", 32'(s_cs_), 32'(e_cs));
      chk("mdl_m_rdy_", 32'(m_rdy_), 32'(e_rdy));
      chk("mdl_m_err", 32'(m_err), 32'(mdl_err));
      chk("mdl_busy", 32'(busy), 32'(mdl_err || mdl_sel >= 0));
      chk("mdl_sel_index", 32'(sel_index), 32'(mdl_last));
      chk("mdl_err_cnt", 32'(err_cnt), 32'(mdl_errs));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] addr_of(input logic [IW-1:0] idx);
    return {idx, 27'h2A5_1C3};
  endfunction

  task automatic strobe(input logic [IW-1:0] idx);
    m_as_  = 1'b0;
    m_addr = addr_of(idx);
    step();
    m_as_  = 1'b1;
  endtask

  initial begin
    reset_ = 1'b0; m_as_ = 1'b1; m_addr = '0; slave_en = 6'h3F; s_rdy_ = '1;
    step(); step();
    chk("rst_s_cs_", 32'(s_cs_), 32'h3F);
    chk("rst_m_rdy_", 32'(m_rdy_), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_sel_index", 32'(sel_index), 32'h0);
    chk("rst_err_cnt", 32'(err_cnt), 32'h0);
    reset_ = 1'b1;
    step();

    // Normal access to slave 5, ready on the third access cycle.
    strobe(3'd5);
    chk("a5_cs", 32'(s_cs_), 32'h1F);
    chk("a5_sel", 32'(sel_index), 32'h5);
    step();
    chk("a5_wait_rdy", 32'(m_rdy_), 32'h1);
    step();
    s_rdy_[5] = 1'b0;
    #1;
    chk("a5_rdy", 32'(m_rdy_), 32'h0);
    chk("a5_err", 32'(m_err), 32'h0);
    step();
    s_rdy_ = '1;
    chk("a5_done_cs", 32'(s_cs_), 32'h3F);
    chk("a5_done_busy", 32'(busy), 32'h0);

    // Disabled slave 2 answers with an error and no chip select.
    slave_en = 6'h3B;
    strobe(3'd2);
    chk("dis_cs", 32'(s_cs_), 32'h3F);
    chk("dis_rdy", 32'(m_rdy_), 32'h0);
    chk("dis_err", 32'(m_err), 32'h1);
    step();
    chk("dis_err_gone", 32'(m_err), 32'h0);
    chk("dis_cnt", 32'(err_cnt), 32'h1);
    slave_en = 6'h3F;

    // Stalled access to slave 0 times out after four select cycles.
    strobe(3'd0);
    for (int c = 0; c < TO; c++) begin
      chk("to_cs_held", 32'(s_cs_), 32'h3E);
      step();
    end
    chk("to_err", 32'(m_err), 32'h1);
    chk("to_cs_off", 32'(s_cs_), 32'h3F);
    step();
    chk("to_cnt", 32'(err_cnt), 32'h2);

    // Ready on the last allowed cycle wins over the timeout.
    strobe(3'd0);
    step(); step(); step();
    s_rdy_[0] = 1'b0;
    #1;
    chk("edge_rdy", 32'(m_rdy_), 32'h0);
    chk("edge_err", 32'(m_err), 32'h0);
    step();
    s_rdy_ = '1;
    chk("edge_idle", 32'(busy), 32'h0);
    step();
    chk("edge_cnt", 32'(err_cnt), 32'h2);

    // Out-of-range indices, then saturation of the 2-bit counter.
    strobe(3'd7);
    chk("oor7_err", 32'(m_err), 32'h1);
    chk("oor7_cs", 32'(s_cs_), 32'h3F);
    step();
    strobe(3'd6);
    chk("oor6_err", 32'(m_err), 32'h1);
    step();
    chk("sat_cnt3", 32'(err_cnt), 32'h3);
    strobe(3'd7);
    step();
    chk("sat_hold", 32'(err_cnt), 32'h3);

    // Access to slave 1 ignores new strobes and foreign ready; reset aborts it.
    strobe(3'd1);
    m_as_ = 1'b0; m_addr = addr_of(3'd4);
    step();
    m_as_ = 1'b1;
    chk("hold_cs", 32'(s_cs_), 32'h3D);
    chk("hold_sel", 32'(sel_index), 32'h1);
    s_rdy_[3] = 1'b0;
    step();
    chk("foreign_cs", 32'(s_cs_), 32'h3D);
    chk("foreign_rdy", 32'(m_rdy_), 32'h1);
    chk("foreign_busy", 32'(busy), 32'h1);
    s_rdy_ = '1;
    reset_ = 1'b0;
    #1;
    chk("arst_cs", 32'(s_cs_), 32'h3F);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_cnt", 32'(err_cnt), 32'h0);
    step();
    reset_ = 1'b1;
    step(); step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
